// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared helpers and types for the single-clock masked FIFO.
//            fifo_addr_w / fifo_lvl_w give the pointer and level widths for a
//            given depth. fifo_status_t bundles the status and sticky error
//            flags into one word so a monitor can compare them in one step.
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Pointer width. A depth of 1 still gets one address bit.
    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit over the pointer so the level can reach DEPTH.
    function automatic int fifo_lvl_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl_mask_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mask_ram
// Purpose  : DEPTH x DATA_WIDTH register array with a per-bit masked write
//            port and a combinational read port. Contents are not reset.
// Ports    : clk       - clock
//            i_we      - write enable
//            i_waddr   - write address
//            i_wdata   - write data
//            i_wmask   - per-bit write enable (1 = update that bit)
//            i_raddr   - read address
//            o_rdata   - read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mask_ram #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_wmask,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Unmasked bits keep whatever the slot held before.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Purpose  : Single-clock parametrised FIFO with per-bit masked writes,
//            optional first-word-fall-through read, live fill level,
//            synchronous flush, threshold flags and sticky error flags.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            fifo_enable                - gates wr_en / rd_en
//            flush                      - synchronous empty-out
//            wr_en, wr_data, wr_mask    - masked write request
//            rd_en, rd_data, rd_valid   - read request / returned word
//            almost_full_limit          - free-slot threshold
//            almost_empty_limit         - occupancy threshold
//            fifo_level                 - current occupancy
//            fifo_full/empty/almost_*   - status flags from the level
//            overflow, underflow, clr_err - sticky error flags and clear
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 12,
    parameter  int FWFT       = 0,
    localparam int ADDR_W     = fifo_addr_w(DEPTH),
    localparam int LVL_W      = fifo_lvl_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_enable,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [LVL_W-1:0]      almost_full_limit,
    input  logic [LVL_W-1:0]      almost_empty_limit,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [LVL_W-1:0] C_DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W:0]   C_DEPTH_EXT = (LVL_W+1)'(DEPTH);

    logic [ADDR_W-1:0]     r_wptr;
    logic [ADDR_W-1:0]     r_rptr;
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_level_nxt;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [LVL_W:0]        w_af_sum;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // ------------------------------------------------------------------
    // Status flags, all derived from the registered level
    // ------------------------------------------------------------------
    assign fifo_level        = r_level;
    assign fifo_full         = (r_level == C_DEPTH_LVL);
    assign fifo_empty        = (r_level == '0);
    // Extra bit keeps the sum from wrapping, so any limit >= DEPTH
    // saturates the flag high on its own.
    assign w_af_sum          = {1'b0, r_level} + {1'b0, almost_full_limit};
    assign fifo_almost_full  = (w_af_sum >= C_DEPTH_EXT);
    assign fifo_almost_empty = (r_level <= almost_empty_limit);

    // ------------------------------------------------------------------
    // Request acceptance; flush overrides both directions
    // ------------------------------------------------------------------
    assign w_wr_acc  = wr_en & fifo_enable & ~fifo_full  & ~flush;
    assign w_rd_acc  = rd_en & fifo_enable & ~fifo_empty & ~flush;
    assign w_ovf_set = wr_en & fifo_enable &  fifo_full  & ~flush;
    assign w_unf_set = rd_en & fifo_enable &  fifo_empty & ~flush;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new set wins over a clear in the same cycle.
    // Flush leaves them alone (the set terms already exclude flush).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mask_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (wr_data),
        .i_wmask (wr_mask),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always on the output; popping advances rptr and
            // the next word shows up as soon as the pointer moves.
            assign rd_data  = w_ram_rdata;
            assign rd_valid = ~fifo_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // rd_data holds its last value between reads; only the
            // valid strobe drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_rd_data  <= w_ram_rdata;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Purpose  : Self-checking bench for sync_fifo_ctrl. One registered-read
//            instance is checked every cycle against a queue-based model;
//            a second FWFT instance is exercised with directed steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;
    import sync_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 12;
    localparam int LW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance signals
    logic          rst_n, fifo_enable, flush, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data, wr_mask, rd_data;
    logic          rd_valid;
    logic [LW-1:0] af_lim, ae_lim, fifo_level;
    logic          fifo_full, fifo_empty, fifo_af, fifo_ae, overflow, underflow;

    // FWFT instance signals
    logic          f_rst_n, f_enable, f_flush, f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_wr_data, f_wr_mask, f_rd_data;
    logic          f_rd_valid;
    logic [LW-1:0] f_level;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    sync_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_enable(fifo_enable), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .almost_full_limit(af_lim), .almost_empty_limit(ae_lim),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_almost_full(fifo_af), .fifo_almost_empty(fifo_ae),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(f_rst_n), .fifo_enable(f_enable), .flush(f_flush),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_mask(f_wr_mask), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .almost_full_limit(4'd2), .almost_empty_limit(4'd2),
        .fifo_level(f_level), .fifo_full(f_full), .fifo_empty(f_empty),
        .fifo_almost_full(f_af), .fifo_almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents as a queue, slot contents kept so that
    // masked writes merge with whatever the slot held before.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_mem[DEPTH];
    int            m_widx;
    logic          m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_widx  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit full, empty, os, us;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        os = 1'b0;
        us = 1'b0;
        if (flush) begin
            m_q.delete();
            m_widx  = 0;
            m_valid = 1'b0;
        end else if (fifo_enable) begin
            os = wr_en && full;
            us = rd_en && empty;
            if (rd_en && !empty) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wr_en && !full) begin
                m_mem[m_widx] = (m_mem[m_widx] & ~wr_mask) | (wr_data & wr_mask);
                m_q.push_back(m_mem[m_widx]);
                m_widx = (m_widx + 1) % DEPTH;
            end
        end else begin
            m_valid = 1'b0;
        end
        m_ovf = os | (m_ovf & !clr_err);
        m_unf = us | (m_unf & !clr_err);
    endtask

    task automatic check_all();
        fifo_status_t so, se;
        so.full         = fifo_full;
        so.empty        = fifo_empty;
        so.almost_full  = fifo_af;
        so.almost_empty = fifo_ae;
        so.overflow     = overflow;
        so.underflow    = underflow;
        se.full         = (m_q.size() == DEPTH);
        se.empty        = (m_q.size() == 0);
        se.almost_full  = (m_q.size() + int'(af_lim)) >= DEPTH;
        se.almost_empty = m_q.size() <= int'(ae_lim);
        se.overflow     = m_ovf;
        se.underflow    = m_unf;
        chk("status", 32'(so), 32'(se));
        chk("level", 32'(fifo_level), 32'(m_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic tick_plain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        fifo_enable = 1'b1; wr_mask = 12'hFFF;
    endtask

    initial begin
        rst_n = 1'b0; f_rst_n = 1'b0;
        fifo_enable = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        wr_data = '0; wr_mask = 12'hFFF; af_lim = 4'd2; ae_lim = 4'd2;
        f_enable = 1'b1; f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0;
        f_wr_data = '0; f_wr_mask = 12'hFFF;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();

        // 1. Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; f_rst_n = 1'b1;
        #1;
        check_all();
        chk("reset_af", 32'(fifo_af), 32'd0);

        // 2. Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
            if (i == 5) chk("af_at_5", 32'(fifo_af), 32'd0);
            if (i == 6) chk("af_at_6", 32'(fifo_af), 32'd1);
        end
        chk("full_at_8", 32'(fifo_full), 32'd1);
        wr_data = 12'h009;
        tick();
        chk("ovf_9th", 32'(overflow), 32'd1);
        chk("level_9th", 32'(fifo_level), 32'd8);
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        rd_en = 1'b0;
        tick();
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // 3. Masked write
        wr_en = 1'b1; wr_data = 12'hABC; wr_mask = 12'hFFF; tick();
        wr_en = 1'b0; rd_en = 1'b1; tick();
        rd_en = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; wr_en = 1'b1; wr_data = 12'h123; wr_mask = 12'h0F0; tick();
        wr_en = 1'b0; wr_mask = 12'hFFF; rd_en = 1'b1; tick();
        chk("masked_merge", 32'(rd_data), 32'h0A2C);
        rd_en = 1'b0; clr_err = 1'b1; tick();
        clr_err = 1'b0;

        // 4. Wrap-around with simultaneous traffic at constant level
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(12'h100 + i); tick();
        end
        rd_en = 1'b1;
        for (int i = 3; i < 23; i++) begin
            wr_data = DW'(12'h100 + i); tick();
            chk("wrap_level", 32'(fifo_level), 32'd3);
        end
        rd_en = 1'b0;

        // 5. Simultaneous at full, underflow, clear
        for (int i = 0; i < 5; i++) begin
            wr_data = DW'(12'h200 + i); tick();
        end
        chk("full_again", 32'(fifo_full), 32'd1);
        rd_en = 1'b1; wr_data = 12'h2FF; tick();
        chk("full_rw_level", 32'(fifo_level), 32'd7);
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        wr_en = 1'b0;
        repeat (7) tick();
        tick();
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_no_valid", 32'(rd_valid), 32'd0);
        rd_en = 1'b0; clr_err = 1'b1; tick();
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        clr_err = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            fifo_enable = ($urandom_range(0, 9) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            clr_err     = ($urandom_range(0, 19) == 0);
            wr_en       = ($urandom_range(0, 99) < 55);
            rd_en       = ($urandom_range(0, 99) < 50);
            wr_data     = DW'($urandom);
            wr_mask     = ($urandom_range(0, 1) == 0) ? 12'hFFF : DW'($urandom);
            if ((n % 16) == 0) begin
                af_lim = LW'($urandom_range(0, 15));
                ae_lim = LW'($urandom_range(0, 15));
            end
            tick();
        end
        idle_in();
        af_lim = 4'd2; ae_lim = 4'd2;
        tick();

        // 6. FWFT instance
        f_wr_en = 1'b1; f_wr_data = 12'h055; tick_plain();
        chk("fwft_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_data", 32'(f_rd_data), 32'h055);
        f_wr_data = 12'h0AA; tick_plain();
        f_wr_en = 1'b0;
        chk("fwft_head_hold", 32'(f_rd_data), 32'h055);
        chk("fwft_level2", 32'(f_level), 32'd2);
        f_rd_en = 1'b1; tick_plain();
        chk("fwft_next", 32'(f_rd_data), 32'h0AA);
        chk("fwft_valid2", 32'(f_rd_valid), 32'd1);
        tick_plain();
        f_rd_en = 1'b0;
        chk("fwft_empty_valid", 32'(f_rd_valid), 32'd0);
        chk("fwft_empty", 32'(f_empty), 32'd1);
        f_enable = 1'b0; f_wr_en = 1'b1; f_wr_data = 12'h077; tick_plain();
        chk("fwft_en0_level", 32'(f_level), 32'd0);
        f_enable = 1'b1;
        repeat (3) tick_plain();
        f_wr_en = 1'b0;
        chk("fwft_fill_level", 32'(f_level), 32'd3);
        f_rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(f_level), 32'd0);
        chk("async_rst_empty", 32'(f_empty), 32'd1);
        chk("async_rst_valid", 32'(f_rd_valid), 32'd0);
        tick_plain();
        f_rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
